sort_result_checker: RTL

- Hardware result checker downstream of the CPU top; consumes `halt` and reads data memory through a dedicated read port.
- On the rising edge of `halt`, reads the "before" window and the "after" window.
- Checks that the after window is non-decreasing (signed) and is a plausible permutation of the before window (sum checksum).
- Reports pass/fail with the first failing index; gives the sorting program a self-checking verdict usable at gate level.

---
 rtl/sort_chk_pkg.sv | 21 ++
 rtl/sort_chk_accum.sv | 62 ++++++
 rtl/sort_result_checker.sv | 111 +++++++++++
 3 files changed

// File: rtl/sort_chk_pkg.sv
// Shared constants for the sort result checker: FSM encoding, default window, response tag.
package sort_chk_pkg;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_BEFORE = 3'd1;
  localparam logic [2:0] S_RD_AFTER  = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam int unsigned DEF_BEFORE_BASE = 1;
  localparam int unsigned DEF_AFTER_BASE  = 11;
  localparam int unsigned DEF_COUNT       = 10;
  localparam int unsigned DEF_WORD_BYTES  = 8;

  // Travels one cycle behind a read request so the returned word can be classified.
  typedef struct packed {
    logic       vld;
    logic       sel_after;
    logic       first;
    logic [7:0] idx;
  } rsp_tag_t;
endpackage

// File: rtl/sort_chk_accum.sv
// Checksum accumulators, previous-word register and first order-violation capture.
// Optional SORT_CHK_XOR_EN adds XOR signatures folded into the mismatch flag.
module sort_chk_accum
  import sort_chk_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  rsp_tag_t          tag,
  input  logic [DATA_W-1:0] data,
  output logic [7:0]        fail_idx,
  output logic              mismatch
);
  logic [DATA_W-1:0] sum_b, sum_a, prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_b    <= '0;
      sum_a    <= '0;
      prev     <= '0;
      fail_idx <= '0;
    end else if (clr) begin
      sum_b    <= '0;
      sum_a    <= '0;
      prev     <= '0;
      fail_idx <= '0;
    end else if (tag.vld) begin
      if (!tag.sel_after) begin
        sum_b <= sum_b + data;
      end else begin
        sum_a <= sum_a + data;
        prev  <= data;
        // Equal neighbours are fine; only the first descent is recorded.
        if (!tag.first && ($signed(data) < $signed(prev)) && (fail_idx == 8'd0))
          fail_idx <= tag.idx;
      end
    end
  end

`ifdef SORT_CHK_XOR_EN
  logic [DATA_W-1:0] xor_b, xor_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xor_b <= '0;
      xor_a <= '0;
    end else if (clr) begin
      xor_b <= '0;
      xor_a <= '0;
    end else if (tag.vld) begin
      if (!tag.sel_after) xor_b <= xor_b ^ data;
      else                xor_a <= xor_a ^ data;
    end
  end

  assign mismatch = (sum_a != sum_b) || (xor_a != xor_b);
`else
  assign mismatch = (sum_a != sum_b);
`endif
endmodule

// File: rtl/sort_result_checker.sv
// Post-halt checker: walks the before/after windows of data memory and reports a sort verdict.
// Build with SORT_CHK_XOR_EN to strengthen the permutation check with XOR signatures.
module sort_result_checker
  import sort_chk_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned BEFORE_BASE = DEF_BEFORE_BASE,
  parameter int unsigned AFTER_BASE  = DEF_AFTER_BASE,
  parameter int unsigned COUNT       = DEF_COUNT,
  parameter int unsigned WORD_BYTES  = DEF_WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        fail_idx,
  output logic              sum_mismatch
);
  localparam logic [ADDR_W-1:0] BB_ADDR  = ADDR_W'(BEFORE_BASE * WORD_BYTES);
  localparam logic [ADDR_W-1:0] AB_ADDR  = ADDR_W'(AFTER_BASE * WORD_BYTES);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(WORD_BYTES);
  localparam logic [7:0]        LAST_CNT = 8'(COUNT - 1);

  logic [2:0] state;
  logic       halt_q, start, sel_after, first, mismatch;
  logic [7:0] cnt, widx;
  rsp_tag_t   rsp;

  assign start = (state == S_IDLE) && halt && !halt_q;
  assign busy  = (state == S_RD_BEFORE) || (state == S_RD_AFTER) || (state == S_DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      halt_q       <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      cnt          <= '0;
      widx         <= '0;
      sel_after    <= 1'b0;
      first        <= 1'b0;
      rsp          <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      sum_mismatch <= 1'b0;
    end else begin
      halt_q <= halt;
      // Tag of the request issued this cycle; its data returns next cycle.
      rsp    <= '{vld: rd_en, sel_after: sel_after, first: first, idx: widx};
      case (state)
        S_IDLE: if (start) begin
          state     <= S_RD_BEFORE;
          rd_en     <= 1'b1;
          rd_addr   <= BB_ADDR;
          widx      <= 8'(BEFORE_BASE);
          cnt       <= '0;
          sel_after <= 1'b0;
          first     <= 1'b0;
        end
        S_RD_BEFORE: begin
          if (cnt == LAST_CNT) begin
            state     <= S_RD_AFTER;
            rd_addr   <= AB_ADDR;
            widx      <= 8'(AFTER_BASE);
            cnt       <= '0;
            sel_after <= 1'b1;
            first     <= 1'b1;
          end else begin
            rd_addr <= rd_addr + STRIDE;
            widx    <= widx + 8'd1;
            cnt     <= cnt + 8'd1;
          end
        end
        S_RD_AFTER: begin
          first <= 1'b0;
          if (cnt == LAST_CNT) begin
            state <= S_DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr + STRIDE;
            widx    <= widx + 8'd1;
            cnt     <= cnt + 8'd1;
          end
        end
        S_DRAIN: state <= S_DONE;
        S_DONE: begin
          done         <= 1'b1;
          sum_mismatch <= mismatch;
          pass         <= (fail_idx == 8'd0) && !mismatch;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sort_chk_accum #(.DATA_W(DATA_W)) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .tag      (rsp),
    .data     (rd_data),
    .fail_idx (fail_idx),
    .mismatch (mismatch)
  );
endmodule
